e_mdu: RTL and testbench
========================

Name: e_mdu

Overview:
- Execute-stage multiply/divide unit for the five-stage pipeline.
- Consumes the two register operands read in Decode, after forwarding, once they reach E.
- Holds the architectural HI/LO registers and models multi-cycle MULT/DIV latency with a busy countdown; the hazard unit stalls D on that busy.
- Provides HI or LO for MFHI/MFLO, which then flows down the normal E-stage result path.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD-class when enabled); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- md_start  input  1  qualifies md_op this cycle; E-stage instruction is an MDU op.
- md_op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB; others = NONE.
- rs_val  input  32  forwarded rs operand (dividend / multiplicand / MT source).
- rt_val  input  32  forwarded rt operand (divisor / multiplier).
- hilo_sel  input  1  0 = LO, 1 = HI for md_out.
- md_busy  output  1  registered; high while a MULT/DIV countdown is in progress.
- md_stall  output  1  md_start & (op is 1..4 or 7..9), OR'd with md_busy; combinational, for the hazard unit.
- md_out  output  32  combinational: hilo_sel ? HI : LO, architectural values.

Behaviour:
- Reset (synchronous): HI=0, LO=0, count=0, md_busy=0, pending result cleared.
  - Reset wins over everything, including mid-operation: pending result discarded, HI/LO=0 on the next cycle.
- States:
  - IDLE (count==0, md_busy=0).
  - RUN (count>0, md_busy=1).
- IDLE + md_start + MULT/MULTU/DIV/DIVU (or MADD-class when enabled):
  - Full 64-bit result computed from rs_val/rt_val at the start edge and latched into a pending register.
  - count loaded with MULT_CYCLES or DIV_CYCLES; md_busy=1 from the next cycle.
- RUN:
  - count decrements each edge.
  - On the edge where count==1: pending result committed to HI/LO, count=0, md_busy=0.
  - Start issued in cycle 0 ⇒ md_busy high in cycles 1..N; new HI/LO and md_busy=0 visible in cycle N+1.
- MULT: {HI,LO} = signed 32x32 → 64 product.
- MULTU: {HI,LO} = unsigned 32x32 → 64 product.
- DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: LO = unsigned quotient, HI = unsigned remainder.
- Divide by zero (rt_val==0, DIV or DIVU): busy countdown still runs for DIV_CYCLES; HI/LO left unchanged at commit.
- MTHI / MTLO in IDLE: HI (resp. LO) = rs_val at that edge; md_busy stays 0; visible on md_out next cycle.
- md_start while md_busy=1 (any op, including MTHI/MTLO): ignored, no state change. The hazard unit must prevent this; an assertion flags it in simulation.
- md_op NONE, or md_start=0: no state change.
- md_out always reflects committed HI/LO, never the pending result. An MFHI issued during RUN is stalled by the hazard unit via md_busy; there is no forwarding from pending.
- No simultaneous-write case arises: MT writes only occur in IDLE, and commits only occur in RUN.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - Ops 7/8/9 are legal and use MULT_CYCLES latency.
  - MADD: {HI,LO} += signed product.
  - MADDU: {HI,LO} += unsigned product.
  - MSUB: {HI,LO} -= signed product.
  - Accumulation base is {HI,LO} sampled at the start edge; 64-bit wrap-around, no saturation.
- Undefined: ops 7/8/9 are treated as NONE (no busy, no write); md_stall does not include them.

Test Plan:
- Reset then hilo_sel=0/1 → md_out=0x00000000 for both.
  - MULT rs=0xFFFFFFFF rt=0x00000002 at cycle 0 → md_busy=1 for cycles 1..5; cycle 6 HI=0xFFFFFFFF, LO=0xFFFFFFFE, md_busy=0.
- MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- DIV rs=0xFFFFFFF9 (-7) rt=0x00000002 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Then DIVU rs=7 rt=0 → 10 busy cycles; HI/LO unchanged.
- MTLO rs=0x12345678 → next cycle md_out (sel=0)=0x12345678, md_busy never high.
  - Then MULT started, MTHI pulsed at cycle 2 → ignored; HI = product high word.
- MULT started, reset asserted in cycle 3 → cycle 4: md_busy=0, HI=LO=0; no later commit.
- With MDU_MADD_EN: LO=5, HI=0, MADD rs=3 rt=4 → LO=0x11, HI=0.
  - MSUB rs=1 rt=0x12 → {HI,LO}=0xFFFFFFFF_FFFFFFFF.
  - Without the macro, op 7 leaves HI/LO unchanged and md_busy low.

Source files
------------

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - E-stage multiply/divide unit with HI/LO and busy countdown; MADD/MADDU/MSUB under MDU_MADD_EN
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_start,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        hilo_sel,
    output logic        md_busy,
    output logic        md_stall,
    output logic [31:0] md_out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
`endif

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      state, state_nxt;
    logic [3:0]  count, count_nxt;
    logic [31:0] hi, lo;
    logic [63:0] pend;
    logic        pend_wr;

    logic        is_mul, is_div, is_acc, is_long, is_mthi, is_mtlo, accept;
    logic        div_zero;
    logic [63:0] prod_s, prod_u, result;
    logic        dvd_neg, dvs_neg;
    logic [31:0] dvd_mag, dvs_mag, q_mag, r_mag, quo, rem;

    always_comb begin
        is_mul  = (md_op == OP_MULT) || (md_op == OP_MULTU);
        is_div  = (md_op == OP_DIV) || (md_op == OP_DIVU);
`ifdef MDU_MADD_EN
        is_acc  = (md_op == OP_MADD) || (md_op == OP_MADDU) || (md_op == OP_MSUB);
`else
        is_acc  = 1'b0;
`endif
        is_long = is_mul || is_div || is_acc;
        is_mthi = (md_op == OP_MTHI);
        is_mtlo = (md_op == OP_MTLO);
        accept  = md_start && (state == S_IDLE);
        div_zero = (rt_val == 32'd0);
    end

    assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Divide on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000 instead of trapping
    always_comb begin
        dvd_neg = (md_op == OP_DIV) && rs_val[31];
        dvs_neg = (md_op == OP_DIV) && rt_val[31];
        dvd_mag = dvd_neg ? (32'd0 - rs_val) : rs_val;
        dvs_mag = div_zero ? 32'd1 : (dvs_neg ? (32'd0 - rt_val) : rt_val);
        q_mag   = dvd_mag / dvs_mag;
        r_mag   = dvd_mag % dvs_mag;
        quo     = (dvd_neg ^ dvs_neg) ? (32'd0 - q_mag) : q_mag;
        rem     = dvd_neg ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        result = 64'd0;
        case (md_op)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV,
            OP_DIVU:  result = {rem, quo};
`ifdef MDU_MADD_EN
            OP_MADD:  result = {hi, lo} + prod_s;
            OP_MADDU: result = {hi, lo} + prod_u;
            OP_MSUB:  result = {hi, lo} - prod_s;
`endif
            default:  result = 64'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            count <= 4'd0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            S_IDLE: begin
                if (accept && is_long) begin
                    state_nxt = S_RUN;
                    count_nxt = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                end
            end
            S_RUN: begin
                count_nxt = count - 4'd1;
                if (count == 4'd1)
                    state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                count_nxt = 4'd0;
            end
        endcase
    end

    always_comb begin
        md_busy  = (state == S_RUN);
        md_stall = (md_start && is_long) || md_busy;
        md_out   = hilo_sel ? hi : lo;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend    <= 64'd0;
            pend_wr <= 1'b0;
        end else begin
            if (accept && is_long) begin
                pend    <= result;
                pend_wr <= !(is_div && div_zero);
            end
            if (accept && is_mthi)
                hi <= rs_val;
            if (accept && is_mtlo)
                lo <= rs_val;
            if ((state == S_RUN) && (count == 4'd1) && pend_wr)
                {hi, lo} <= pend;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset)
            assert (!(md_start && md_busy && (is_long || is_mthi || is_mtlo)))
                else $warning("e_mdu: md_start while md_busy, op %0d ignored", md_op);
    end
`endif

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - self-checking bench for e_mdu against a behavioural HI/LO model
module tb_e_mdu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        md_start = 1'b0;
    logic [3:0]  md_op = 4'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        hilo_sel = 1'b0;
    logic        md_busy, md_stall;
    logic [31:0] md_out;

    int n_checks = 0;
    int n_fails  = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    e_mdu dut (
        .clk(clk), .reset(reset), .md_start(md_start), .md_op(md_op),
        .rs_val(rs_val), .rt_val(rt_val), .hilo_sel(hilo_sel),
        .md_busy(md_busy), .md_stall(md_stall), .md_out(md_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
            else begin
                n_fails++;
                $error("FAIL %s: got %h expected %h", tag, obs, exp);
            end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] e_hi, input logic [31:0] e_lo);
        hilo_sel = 1'b0;
        #1;
        chk({tag, "_lo"}, md_out, e_lo);
        hilo_sel = 1'b1;
        #1;
        chk({tag, "_hi"}, md_out, e_hi);
    endtask

    function automatic int lat(input logic [3:0] op);
        case (op)
            4'd1, 4'd2: return 5;
            4'd3, 4'd4: return 10;
`ifdef MDU_MADD_EN
            4'd7, 4'd8, 4'd9: return 5;
`endif
            default: return 0;
        endcase
    endfunction

    // Architectural effect of one accepted op, straight from the ISA rules
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] acc, pu;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        acc = {m_hi, m_lo};
        pu  = {32'd0, a} * {32'd0, b};
        case (op)
            4'd1: {m_hi, m_lo} = 64'(sa * sb);
            4'd2: {m_hi, m_lo} = pu;
            4'd3: if (b != 0) begin
                q = sa / sb;
                r = sa % sb;
                m_lo = 32'(q);
                m_hi = 32'(r);
            end
            4'd4: if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            4'd5: m_hi = a;
            4'd6: m_lo = a;
`ifdef MDU_MADD_EN
            4'd7: {m_hi, m_lo} = acc + 64'(sa * sb);
            4'd8: {m_hi, m_lo} = acc + pu;
            4'd9: {m_hi, m_lo} = acc - 64'(sa * sb);
`endif
            default: ;
        endcase
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        logic [31:0] o_hi, o_lo;
        n = lat(op);
        o_hi = m_hi;
        o_lo = m_lo;
        md_start = 1'b1;
        md_op = op;
        rs_val = a;
        rt_val = b;
        #1;
        chk({tag, "_stall0"}, 32'(md_stall), 32'(n > 0));
        tick();
        md_start = 1'b0;
        md_op = 4'd0;
        model(op, a, b);
        for (int i = 1; i <= n; i++) begin
            chk({tag, "_busy"}, 32'(md_busy), 32'd1);
            if (i == 1 || i == n)
                chk_out({tag, "_old"}, o_hi, o_lo);
            tick();
        end
        chk({tag, "_idle"}, 32'(md_busy), 32'd0);
        chk_out(tag, m_hi, m_lo);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [3:0]  ops [$];

        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", 32'(md_busy), 32'd0);
        chk_out("rst", 32'd0, 32'd0);

        run_op("mult",  4'd1, 32'hFFFF_FFFF, 32'h0000_0002);
        chk("mult_hi_const", m_hi, 32'hFFFF_FFFF);
        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'h0000_0002);
        run_op("div",   4'd3, 32'hFFFF_FFF9, 32'h0000_0002);
        chk_out("div_const", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu0", 4'd4, 32'd7, 32'd0);
        chk_out("divu0_const", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        chk_out("divovf_const", 32'd0, 32'h8000_0000);
        run_op("mtlo", 4'd6, 32'h1234_5678, 32'd0);
        chk_out("mtlo_const", 32'd0, 32'h1234_5678);

        // MTHI during RUN must be dropped
        md_start = 1'b1; md_op = 4'd1; rs_val = 32'h0001_0000; rt_val = 32'h0001_0000;
        tick();
        md_start = 1'b0; md_op = 4'd0;
        tick();
        md_start = 1'b1; md_op = 4'd5; rs_val = 32'hDEAD_BEEF;
        #1;
        chk("mthi_busy_stall", 32'(md_stall), 32'd1);
        tick();
        md_start = 1'b0; md_op = 4'd0;
        for (int i = 3; i <= 5; i++) tick();
        m_hi = 32'd1;
        m_lo = 32'd0;
        chk("mthi_ign_busy", 32'(md_busy), 32'd0);
        chk_out("mthi_ign", m_hi, m_lo);

        // Reset in the middle of a MULT
        md_start = 1'b1; md_op = 4'd1; rs_val = 32'h7; rt_val = 32'h9;
        tick();
        md_start = 1'b0; md_op = 4'd0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        chk("midrst_busy", 32'(md_busy), 32'd0);
        chk_out("midrst", 32'd0, 32'd0);
        for (int i = 0; i < 6; i++) tick();
        chk("midrst_late_busy", 32'(md_busy), 32'd0);
        chk_out("midrst_late", 32'd0, 32'd0);

        run_op("mtlo5", 4'd6, 32'd5, 32'd0);
        run_op("mthi0", 4'd5, 32'd0, 32'd0);
`ifdef MDU_MADD_EN
        run_op("madd", 4'd7, 32'd3, 32'd4);
        chk_out("madd_const", 32'd0, 32'h11);
        run_op("msub", 4'd9, 32'd1, 32'h12);
        chk_out("msub_const", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
`else
        run_op("op7", 4'd7, 32'd3, 32'd4);
        chk_out("op7_const", 32'd0, 32'd5);
        ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
`endif

        for (int k = 0; k < 24; k++) begin
            op = ops[$urandom_range(0, ops.size() - 1)];
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'd0;
            if ($urandom_range(0, 3) == 0) b = b & 32'h0000_00FF;
            run_op("rnd", op, a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
